// File: rtl/fetch_pc_unit_pkg.sv
// fetch_pkg: shared widths, NOP encoding and enums for the fetch stage.
package fetch_pkg;
    localparam int PC_W = 14;
    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;
    typedef enum logic [1:0] {IDLE, RUN, HALTED} fetch_state_t;
    typedef enum logic [2:0] {SEL_SEQ, SEL_BRANCH, SEL_JUMP, SEL_JREG, SEL_HOLD} pc_sel_t;
endpackage

// File: rtl/fetch_pc_unit_if.sv
// fetch_pc_unit_if: control, memory and IF/ID signals of the fetch stage.
// FETCH_MISALIGN_TRAP_EN adds the sticky misaligned flag.
interface fetch_pc_unit_if;
    import fetch_pkg::*;
    logic stall;
    logic halt;
    logic branch_taken;
    logic [PC_W-1:0] branch_base;
    logic [15:0] branch_offset;
    logic jump;
    logic [25:0] jump_target;
    logic jump_reg;
    logic [31:0] reg_target;
    logic [INSTR_W-1:0] instruction_in;
    logic [PC_W-1:0] program_counter;
    logic [INSTR_W-1:0] if_id_instruction;
    logic [PC_W-1:0] if_id_pc_plus4;
    logic if_id_valid;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic misaligned;
`endif
    modport master(
        input stall, halt, branch_taken, branch_base, branch_offset, jump, jump_target,
        input jump_reg, reg_target, instruction_in,
`ifdef FETCH_MISALIGN_TRAP_EN
        output misaligned,
`endif
        output program_counter, if_id_instruction, if_id_pc_plus4, if_id_valid
    );
    modport slave(
        output stall, halt, branch_taken, branch_base, branch_offset, jump, jump_target,
        output jump_reg, reg_target, instruction_in,
`ifdef FETCH_MISALIGN_TRAP_EN
        input misaligned,
`endif
        input program_counter, if_id_instruction, if_id_pc_plus4, if_id_valid
    );
endinterface

// File: rtl/fetch_pc_unit_next_pc.sv
// fetch_next_pc: next-PC priority select and redirect target arithmetic.
// With FETCH_MISALIGN_TRAP_EN a misaligned redirect raises trap instead of loading.
module fetch_next_pc import fetch_pkg::*; (
    input  logic            run,
    input  logic            halt,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic            jump,
    input  logic            jump_reg,
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] branch_base,
    input  logic [15:0]     branch_offset,
    input  logic [25:0]     jump_target,
    input  logic [31:0]     reg_target,
    output pc_sel_t         pc_sel,
    output logic [PC_W-1:0] next_pc,
    output logic            trap
);
    logic [PC_W-1:0] target;
    // Sign-extension bits of the offset fall off the top after truncation to PC_W.
    logic unused_bits;
    assign unused_bits = ^{reg_target[31:PC_W], jump_target[25:PC_W-2], branch_offset[15:PC_W-2]};
    always_comb begin
        target = jump_reg ? reg_target[PC_W-1:0]
               : jump ? {jump_target[PC_W-3:0], 2'b00}
               : branch_base + {branch_offset[PC_W-3:0], 2'b00};
        if (!run || halt) pc_sel = SEL_HOLD;
        else if (jump_reg) pc_sel = SEL_JREG;
        else if (jump) pc_sel = SEL_JUMP;
        else if (branch_taken) pc_sel = SEL_BRANCH;
        else if (stall) pc_sel = SEL_HOLD;
        else pc_sel = SEL_SEQ;
`ifdef FETCH_MISALIGN_TRAP_EN
        trap = (pc_sel inside {SEL_BRANCH, SEL_JUMP, SEL_JREG}) && target[1:0] != 2'b00;
        next_pc = (pc_sel == SEL_HOLD || trap) ? pc : pc_sel == SEL_SEQ ? pc + PC_W'(4) : target;
`else
        trap = 1'b0;
        next_pc = pc_sel == SEL_HOLD ? pc : pc_sel == SEL_SEQ ? pc + PC_W'(4) : target & ~PC_W'(3);
`endif
    end
endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: owns the PC, IF/ID register and IDLE/RUN/HALTED state.
// Optional FETCH_MISALIGN_TRAP_EN traps misaligned redirects into HALTED.
module fetch_pc_unit import fetch_pkg::*; #(
    parameter logic [PC_W-1:0] RESET_PC = 14'h0000
) (
    input logic clk,
    input logic reset,
    fetch_pc_unit_if.master bus
);
    fetch_state_t state, state_nxt;
    pc_sel_t pc_sel;
    logic [PC_W-1:0] pc, next_pc;
    logic trap, flush;
    fetch_next_pc u_next_pc (
        .run(state == RUN),
        .halt(bus.halt),
        .stall(bus.stall),
        .branch_taken(bus.branch_taken),
        .jump(bus.jump),
        .jump_reg(bus.jump_reg),
        .pc(pc),
        .branch_base(bus.branch_base),
        .branch_offset(bus.branch_offset),
        .jump_target(bus.jump_target),
        .reg_target(bus.reg_target),
        .pc_sel(pc_sel),
        .next_pc(next_pc),
        .trap(trap)
    );
    assign bus.program_counter = pc;
    // Any redirect, halt or trap discards the wrong-path word fetched this cycle.
    assign flush = state == RUN && (bus.halt || trap || pc_sel inside {SEL_BRANCH, SEL_JUMP, SEL_JREG});
    always_comb begin
        state_nxt = state;
        if (state == IDLE) state_nxt = RUN;
        else if (state == RUN && (bus.halt || trap)) state_nxt = HALTED;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            pc <= RESET_PC;
        end else begin
            state <= state_nxt;
            pc <= next_pc;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset || flush) begin
            bus.if_id_instruction <= NOP_INSTR;
            bus.if_id_pc_plus4 <= '0;
            bus.if_id_valid <= 1'b0;
        end else if (state == RUN && pc_sel != SEL_HOLD) begin
            bus.if_id_instruction <= bus.instruction_in;
            bus.if_id_pc_plus4 <= pc + PC_W'(4);
            bus.if_id_valid <= 1'b1;
        end
    end
`ifdef FETCH_MISALIGN_TRAP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) bus.misaligned <= 1'b0;
        else if (state == RUN && trap) bus.misaligned <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: directed scoreboard bench for fetch_pc_unit with a big-endian word memory model.
// Covers both builds of FETCH_MISALIGN_TRAP_EN.
module tb_fetch_pc_unit;
    import fetch_pkg::*;
    typedef struct {
        logic [13:0] pc;
        logic [31:0] instr;
        logic [13:0] p4;
        logic        valid;
        logic        mis;
    } exp_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    exp_t sb[$];
    int vectors = 0;
    int miscompares = 0;
    always #5 clk = ~clk;
    fetch_pc_unit_if bus();
    fetch_pc_unit #(.RESET_PC(14'h0000)) dut (.clk(clk), .reset(reset), .bus(bus));
    function automatic logic [31:0] mem_word(input logic [13:0] a);
        return a == 14'd0 ? 32'h2008_0005 : {16'hC0DE, 2'b00, a};
    endfunction
    assign bus.instruction_in = mem_word(bus.program_counter);
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic push(input logic [13:0] pc, input logic [31:0] instr, input logic [13:0] p4,
                        input logic valid, input logic mis);
        exp_t e;
        e.pc = pc; e.instr = instr; e.p4 = p4; e.valid = valid; e.mis = mis;
        sb.push_back(e);
    endtask
    task automatic compare(input string tag);
        exp_t e;
        e = sb.pop_front();
        check({tag, ".pc"}, 32'(bus.program_counter), 32'(e.pc));
        check({tag, ".instr"}, bus.if_id_instruction, e.instr);
        check({tag, ".pc_plus4"}, 32'(bus.if_id_pc_plus4), 32'(e.p4));
        check({tag, ".valid"}, 32'(bus.if_id_valid), 32'(e.valid));
`ifdef FETCH_MISALIGN_TRAP_EN
        check({tag, ".misaligned"}, 32'(bus.misaligned), 32'(e.mis));
`endif
    endtask
    task automatic step(input string tag, input logic [13:0] pc, input logic [31:0] instr,
                        input logic [13:0] p4, input logic valid, input logic mis = 1'b0);
        push(pc, instr, p4, valid, mis);
        @(posedge clk);
        #1;
        compare(tag);
    endtask
    task automatic clear();
        bus.stall = 0; bus.halt = 0; bus.branch_taken = 0; bus.branch_base = '0;
        bus.branch_offset = '0; bus.jump = 0; bus.jump_target = '0; bus.jump_reg = 0;
        bus.reg_target = '0;
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
    initial begin
        clear();
        repeat (2) @(posedge clk);
        #1;
        push(14'd0, 32'h0, 14'd0, 1'b0, 1'b0);
        compare("reset");
        reset = 1'b0;
        step("idle", 14'd0, 32'h0, 14'd0, 1'b0);
        step("first", 14'd4, 32'h2008_0005, 14'd4, 1'b1);
        step("seq", 14'd8, mem_word(14'd4), 14'd8, 1'b1);
        bus.stall = 1;
        repeat (3) step("stall", 14'd8, mem_word(14'd4), 14'd8, 1'b1);
        bus.stall = 0;
        step("unstall", 14'd12, mem_word(14'd8), 14'd12, 1'b1);
        bus.branch_taken = 1; bus.branch_base = 14'd20; bus.branch_offset = 16'hFFFE;
        step("branch", 14'd12, 32'h0, 14'd0, 1'b0);
        clear();
        step("branch_fetch", 14'd16, mem_word(14'd12), 14'd16, 1'b1);
        bus.branch_taken = 1; bus.branch_base = 14'd100; bus.branch_offset = 16'd1;
        bus.jump_reg = 1; bus.stall = 1; bus.reg_target = 32'h0000_0040;
        step("jreg_prio", 14'd64, 32'h0, 14'd0, 1'b0);
        clear();
        step("jreg_fetch", 14'd68, mem_word(14'd64), 14'd68, 1'b1);
        bus.jump = 1; bus.jump_target = 26'h200_0FFF; bus.branch_taken = 1; bus.branch_base = 14'h100;
        step("jump_prio", 14'd16380, 32'h0, 14'd0, 1'b0);
        clear();
        step("wrap", 14'd0, mem_word(14'd16380), 14'd0, 1'b1);
        step("post_wrap", 14'd4, 32'h2008_0005, 14'd4, 1'b1);
        bus.branch_taken = 1; bus.branch_base = 14'h3FF0; bus.branch_offset = 16'h0008;
        step("branch_ovf", 14'd16, 32'h0, 14'd0, 1'b0);
        clear();
        step("branch_ovf_fetch", 14'd20, mem_word(14'd16), 14'd20, 1'b1);
        bus.halt = 1;
        step("halt", 14'd20, 32'h0, 14'd0, 1'b0);
        bus.halt = 0; bus.jump = 1; bus.jump_target = 26'd5;
        step("halt_jump", 14'd20, 32'h0, 14'd0, 1'b0);
        bus.jump = 0;
        step("halt_hold", 14'd20, 32'h0, 14'd0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        push(14'd0, 32'h0, 14'd0, 1'b0, 1'b0);
        compare("halt_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        step("idle2", 14'd0, 32'h0, 14'd0, 1'b0);
        step("run2", 14'd4, 32'h2008_0005, 14'd4, 1'b1);
`ifdef FETCH_MISALIGN_TRAP_EN
        bus.jump_reg = 1; bus.reg_target = 32'd6;
        step("misalign", 14'd4, 32'h0, 14'd0, 1'b0, 1'b1);
        clear();
        step("misalign_halted", 14'd4, 32'h0, 14'd0, 1'b0, 1'b1);
`else
        bus.jump_reg = 1; bus.reg_target = 32'hFFFF_0016;
        step("jreg_mask", 14'd20, 32'h0, 14'd0, 1'b0);
        clear();
        step("jreg_mask_fetch", 14'd24, mem_word(14'd20), 14'd24, 1'b1);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
Instruction-fetch stage that sits directly upstream of the 14-bit byte-addressed, big-endian instruction memory. It owns the program counter and drives it to the memory's program_counter input. It receives the 32-bit word back combinationally and registers it, with PC+4, into the IF/ID pipeline register. It also applies redirect (branch, jump, jump-register), stall, flush and halt control.

Parameters:
PC_W, 14, program counter width in bits (byte address into the 16384-byte memory)
INSTR_W, 32, instruction width
RESET_PC, 14'h0000, PC value loaded on reset

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
stall  in  1  hold PC and IF/ID contents
halt  in  1  enter HALTED state (halt instruction decoded downstream)
branch_taken  in  1  redirect to branch target
branch_base  in  PC_W  PC+4 of the branching instruction
branch_offset  in  16  signed word offset
jump  in  1  redirect to absolute jump target
jump_target  in  26  word address field of the jump
jump_reg  in  1  redirect to register value
reg_target  in  32  register value for jump_reg
instruction_in  in  INSTR_W  word returned by the instruction memory
program_counter  out  PC_W  address to the instruction memory
if_id_instruction  out  INSTR_W  registered instruction
if_id_pc_plus4  out  PC_W  registered PC+4
if_id_valid  out  1  IF/ID holds a real instruction

Behaviour:
- Reset (async, any cycle, including mid-redirect or mid-stall):
  - program_counter = RESET_PC
  - if_id_instruction = 0 (NOP); if_id_pc_plus4 = 0; if_id_valid = 0
  - state = IDLE
- States:
  - IDLE: one cycle after reset release. No fetch is captured and the PC holds. Next state is RUN.
  - RUN: normal fetch.
  - HALTED: the PC holds, if_id_valid = 0 and IF/ID holds NOP. The block exits only on reset.
- RUN next-PC priority, highest first:
  1. halt: go to HALTED, PC holds, IF/ID is flushed.
  2. jump_reg: PC = reg_target[PC_W-1:0].
  3. jump: PC = {jump_target, 2'b00}[PC_W-1:0].
  4. branch_taken: PC = branch_base + (sext(branch_offset) << 2), truncated to PC_W bits.
  5. stall: PC and IF/ID hold.
  6. Otherwise: PC = PC + 4.
- Redirect (priorities 2–4) overrides stall. On redirect, IF/ID loads NOP with if_id_valid = 0 (flush of the wrong-path fetch).
- Sequential fetch: IF/ID captures instruction_in, PC+4 and valid = 1.
- Latency: one cycle from program_counter to if_id_instruction. A redirect is visible on program_counter the cycle after it is asserted.
- Arithmetic: all PC arithmetic is modulo 2^PC_W. The address 16380 + 4 wraps to 0 with no flag. Overflow of the sign-extended branch add is discarded.
- Control inputs are ignored in IDLE and HALTED, except reset.

Optional Feature:
FETCH_MISALIGN_TRAP_EN
- Defined:
  - Adds output misaligned (1 bit, reset 0).
  - A redirect whose target has bits [1:0] != 0 is not taken. Instead the block sets misaligned = 1 (sticky until reset), goes to HALTED and flushes IF/ID.
- Undefined:
  - The port is absent.
  - Target bits [1:0] are forced to 00 before loading the PC.

Decomposition:
- Package fetch_pkg:
  - constants PC_W, INSTR_W, NOP_INSTR = 32'h0000_0000
  - enum fetch_state_t {IDLE, RUN, HALTED}
  - enum pc_sel_t {SEL_SEQ, SEL_BRANCH, SEL_JUMP, SEL_JREG, SEL_HOLD}
- Sub-module: fetch_next_pc, a combinational priority select plus target arithmetic that produces next_pc and pc_sel.
- The parent keeps the state register, the PC register and the IF/ID register.

Test Plan:
- Reset, then release; memory preloaded with 32'h2008_0005 at bytes 0–3. Required: cycle 1 IDLE, valid = 0. Next edge: PC = 4, if_id_instruction = 32'h2008_0005, if_id_pc_plus4 = 4, valid = 1.
- In RUN at PC = 8, assert stall for 3 cycles. Required: PC stays 8 and IF/ID is unchanged. On release, PC = 12.
- Assert branch_taken with branch_base = 20, offset = 16'hFFFE. Required: next PC = 12, IF/ID valid = 0. One cycle later the word at 12 is captured.
- Assert branch_taken and jump_reg together, with stall = 1 and reg_target = 32'h0000_0040. Required: PC = 64 (jump_reg wins over branch and stall), flush occurs.
- Start at PC = 16380 with sequential fetch. Required: next PC = 0 and if_id_pc_plus4 = 0.
- Assert halt, then toggle jump. Required: PC frozen, valid = 0. Assert reset mid-halt: PC = RESET_PC, state = IDLE. With FETCH_MISALIGN_TRAP_EN defined, jump_reg with reg_target = 6: misaligned = 1 and HALTED.
